muldiv_sequencer: RTL and testbench

Multi-cycle controller for the RV32M multiply/divide operations (alufn 5'b1xxxx). It takes one M-extension operation from the EX stage and runs a radix-2 iterative shift-add multiply or restoring divide on operand magnitudes. It stalls the pipeline until the result is ready, then presents the 32-bit result with a one-cycle `done` pulse. It takes over M-extension operations from the single-cycle ALU path, so the EX stage no longer needs combinational 32x32 multiply and divide logic.

---
 rtl/muldiv_pkg.sv | 50 +++++
 rtl/muldiv_datapath.sv | 77 +++++++
 rtl/muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: alufn M-codes, sequencer state type, operand decode helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

   localparam int XLEN = 32;

   // alufn codes for the M extension, also decoded by the single-cycle ALU
   localparam logic [4:0] ALU_MUL    = 5'b10000;
   localparam logic [4:0] ALU_MULH   = 5'b10001;
   localparam logic [4:0] ALU_MULHSU = 5'b10010;
   localparam logic [4:0] ALU_MULHU  = 5'b10011;
   localparam logic [4:0] ALU_DIV    = 5'b10100;
   localparam logic [4:0] ALU_DIVU   = 5'b10101;
   localparam logic [4:0] ALU_REM    = 5'b10110;
   localparam logic [4:0] ALU_REMU   = 5'b10111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FSM  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   function automatic logic op_is_div(input logic [4:0] op);
      return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

   function automatic logic op_is_rem(input logic [4:0] op);
      return op inside {ALU_REM, ALU_REMU};
   endfunction

   function automatic logic op_a_signed(input logic [4:0] op);
      return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
   endfunction

   function automatic logic op_b_signed(input logic [4:0] op);
      return op inside {ALU_MULH, ALU_DIV, ALU_REM};
   endfunction

   // High product word for MULH*, remainder half of the register for REM*
   function automatic logic op_hi_word(input logic [4:0] op);
      return op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};
   endfunction

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic neg);
      return neg ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative radix-2 datapath: shift-add multiply or restoring divide on magnitudes, plus sign fix-up.
// Latency: one bit per step_i cycle; result_o is combinational from the register after 32 steps.
// Backpressure: none; the sequencer paces it with load_i/step_i.
module muldiv_datapath
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            is_div_i,
   input  logic            hi_i,
   input  logic            neg_i,
   input  logic [XLEN-1:0] mag_a_i,
   input  logic [XLEN-1:0] mag_b_i,
   output logic [XLEN-1:0] result_o
);

   // acc: {product_hi, multiplier/product_lo} or {remainder, quotient}
   logic [2*XLEN-1:0] acc_q, acc_d;
   // multiplicand or divisor magnitude
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [XLEN:0]     add_op1, add_op2, add_sum;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   word, word_s;

   // Shared 33-bit adder: adds for multiply, trial subtract for divide
   always_comb begin
      add_op1 = is_div_i ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_op2 = {1'b0, opnd_q};
      add_sum = is_div_i ? (add_op1 - add_op2) : (add_op1 + add_op2);
   end

   // Next-state of the shift register: load, one iteration, or hold
   always_comb begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      if (load_i) begin
         if (is_div_i) begin
            acc_d  = {{XLEN{1'b0}}, mag_a_i};
            opnd_d = mag_b_i;
         end else begin
            acc_d  = {{XLEN{1'b0}}, mag_b_i};
            opnd_d = mag_a_i;
         end
      end else if (step_i) begin
         if (is_div_i) begin
            // sign bit of the trial difference is the borrow: restore on borrow
            if (!add_sum[XLEN]) acc_d = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
         end else begin
            if (acc_q[0]) acc_d = {add_sum, acc_q[XLEN-1:1]};
            else          acc_d = {1'b0, acc_q[2*XLEN-1:1]};
         end
      end
   end

   // Result selection with negate-on-sign: 64-bit for products, 32-bit for quotient/remainder
   always_comb begin
      prod_s   = neg_i ? (~acc_q + 1'b1) : acc_q;
      word     = hi_i ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      word_s   = neg_i ? (~word + 1'b1) : word;
      result_o = is_div_i ? word_s : (hi_i ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0]);
   end

   // Shift register and operand storage
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         opnd_q <= '0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: accepts one M op, iterates 32 cycles, sign-fixes, pulses done.
// Latency: done 34 cycles after accept (1 cycle for divide-by-zero / signed overflow).
// Backpressure: combinational stall from issue until the cycle before done; flush aborts.
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4:0]      alufn,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   md_state_e       state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [4:0]      op_q, op_d;
   logic            sign_q, sign_d;
   logic            busy_q, done_q;
   logic [XLEN-1:0] result_q, result_d;

   logic            issue_ok, accept, a_neg, b_neg, res_neg;
   logic            div_zero, ovf, special;
   logic [XLEN-1:0] mag_a, mag_b, special_res, dp_result;
   logic            dp_load, dp_step, dp_div;

   // Issue decode: accept qualification, operand magnitudes, result sign, one-cycle special cases
   always_comb begin
      issue_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);
      accept   = start & alufn[4] & ~flush;
      a_neg    = op_a_signed(alufn) & a[XLEN-1];
      b_neg    = op_b_signed(alufn) & b[XLEN-1];
      mag_a    = magnitude(a, a_neg);
      mag_b    = magnitude(b, b_neg);
      // remainder follows the dividend; products and quotients follow sign(a)^sign(b)
      res_neg  = op_is_rem(alufn) ? a_neg : (a_neg ^ b_neg);
      div_zero = op_is_div(alufn) && (b == '0);
      ovf      = ((alufn == ALU_DIV) || (alufn == ALU_REM)) &&
                 (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      special  = div_zero | ovf;
      if (div_zero) special_res = op_is_rem(alufn) ? a : 32'hFFFF_FFFF;
      else          special_res = op_is_rem(alufn) ? 32'h0 : 32'h8000_0000;
      stall    = (accept & issue_ok) | (state_q == ST_ITER) | (state_q == ST_FSM);
      // datapath sees the incoming op on the load cycle, the latched op afterwards
      dp_div   = (accept & issue_ok) ? op_is_div(alufn) : op_is_div(op_q);
   end

   // FSM next-state, counter, datapath controls and result load; flush overrides all
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_d   = sign_q;
      result_d = result_q;
      dp_load  = 1'b0;
      dp_step  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               op_d   = alufn;
               sign_d = res_neg;
               cnt_d  = '0;
               if (special) begin
                  state_d  = ST_DONE;
                  result_d = special_res;
               end else begin
                  state_d = ST_ITER;
                  dp_load = 1'b1;
               end
            end
         end
         ST_ITER: begin
            dp_step = 1'b1;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = ST_FSM;
         end
         ST_FSM: begin
            result_d = dp_result;
            state_d  = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         result_d = result_q;
         dp_step  = 1'b0;
      end
   end

   // State, counter, latched op and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         sign_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_q   <= sign_d;
         busy_q   <= (state_d == ST_ITER) || (state_d == ST_FSM);
         done_q   <= (state_d == ST_DONE);
         result_q <= result_d;
      end
   end

   muldiv_datapath u_datapath (
      .clk      (clk),
      .rst      (rst),
      .load_i   (dp_load),
      .step_i   (dp_step),
      .is_div_i (dp_div),
      .hi_i     (op_hi_word(op_q)),
      .neg_i    (sign_q),
      .mag_a_i  (mag_a),
      .mag_b_i  (mag_b),
      .result_o (dp_result)
   );

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vectors, random ops against an arithmetic model, abort and issue rules.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_sequencer;

   localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010, OP_MULHU = 5'b10011;
   localparam logic [4:0] OP_DIV = 5'b10100, OP_DIVU = 5'b10101, OP_REM = 5'b10110, OP_REMU = 5'b10111;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [4:0]  alufn;
   logic [31:0] a, b;
   logic        stall, busy, done;
   logic [31:0] result;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] last_res;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] res;
      int          lat;
   } vec_t;

   muldiv_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .alufn  (alufn),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Arithmetic reference: 64-bit integer math on sign/zero-extended operands
   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, ux, uy, r;
      logic [63:0] p;
      logic [31:0] res;
      sx = $signed(x);
      sy = $signed(y);
      ux = {32'b0, x};
      uy = {32'b0, y};
      res = 32'h0;
      case (op)
         OP_MUL:    begin r = sx * sy; res = r[31:0];  end
         OP_MULH:   begin r = sx * sy; res = r[63:32]; end
         OP_MULHSU: begin r = sx * uy; res = r[63:32]; end
         OP_MULHU:  begin p = {32'b0, x} * {32'b0, y}; res = p[63:32]; end
         OP_DIV:    begin if (y == 0) res = 32'hFFFF_FFFF; else begin r = sx / sy; res = r[31:0]; end end
         OP_DIVU:   begin if (y == 0) res = 32'hFFFF_FFFF; else begin r = ux / uy; res = r[31:0]; end end
         OP_REM:    begin if (y == 0) res = x; else begin r = sx % sy; res = r[31:0]; end end
         OP_REMU:   begin if (y == 0) res = x; else begin r = ux % uy; res = r[31:0]; end end
         default:   res = 32'h0;
      endcase
      return res;
   endfunction

   function automatic int model_lat(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      logic is_div, is_sdiv;
      is_div  = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
      is_sdiv = (op == OP_DIV) || (op == OP_REM);
      if (is_div && y == 0) return 1;
      if (is_sdiv && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issue one op for a single cycle, then measure edges to done, stall and busy cycles.
   // Returns inside the done cycle, #1 after the falling edge.
   task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int stalls, output int busys, output logic [31:0] res);
      lat = 0; stalls = 0; busys = 0;
      @(negedge clk);
      alufn = op; a = x; b = y; start = 1'b1;
      #1; if (stall) stalls++;
      @(posedge clk); lat = 1;
      @(negedge clk); start = 1'b0; #1;
      while (done !== 1'b1 && lat < 100) begin
         if (stall) stalls++;
         if (busy) busys++;
         @(posedge clk); lat++;
         @(negedge clk); #1;
      end
      res = result;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; alufn = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      n_checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
      rst = 1'b0;
      last_res = 32'h0;
   endtask

   task automatic test_directed();
      vec_t        tbl [12];
      int          lat, stalls, busys;
      logic [31:0] res;
      tbl[0]  = '{OP_MUL,    32'd7,          32'd6,          32'h0000_002A, 34};
      tbl[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 34};
      tbl[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 34};
      tbl[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 34};
      tbl[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34};
      tbl[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 34};
      tbl[6]  = '{OP_DIVU,   32'd100,        32'd7,          32'd14,        34};
      tbl[7]  = '{OP_REMU,   32'd100,        32'd7,          32'd2,         34};
      tbl[8]  = '{OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, 1};
      tbl[9]  = '{OP_REM,    32'd5,          32'd0,          32'd5,         1};
      tbl[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1};
      tbl[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1};
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].op, tbl[i].x, tbl[i].y, lat, stalls, busys, res);
         n_checks++; if (res !== tbl[i].res) $display("FAIL directed_result[%0d]: got %h want %h", i, res, tbl[i].res); else n_pass++;
         n_checks++; if (lat != tbl[i].lat) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, tbl[i].lat); else n_pass++;
         // stall covers issue..done-1, busy covers the cycles strictly between issue and done
         n_checks++; if (stalls != tbl[i].lat) $display("FAIL directed_stall_cycles[%0d]: got %0d want %0d", i, stalls, tbl[i].lat); else n_pass++;
         n_checks++; if (busys != tbl[i].lat - 1) $display("FAIL directed_busy_cycles[%0d]: got %0d want %0d", i, busys, tbl[i].lat - 1); else n_pass++;
         last_res = tbl[i].res;
      end
   endtask

   task automatic test_random();
      logic [4:0]  op;
      logic [31:0] x, y, exp_res, res;
      logic [31:0] edge_vals [5];
      int          lat, stalls, busys, exp_lat;
      edge_vals[0] = 32'h0; edge_vals[1] = 32'h1; edge_vals[2] = 32'hFFFF_FFFF;
      edge_vals[3] = 32'h8000_0000; edge_vals[4] = 32'h7FFF_FFFF;
      for (int i = 0; i < 60; i++) begin
         op = {2'b10, 3'($urandom_range(0, 7))};
         x = $urandom; y = $urandom;
         case ($urandom_range(0, 5))
            1: begin x = 32'($urandom_range(0, 40)) - 32'd20; y = 32'($urandom_range(0, 40)) - 32'd20; end
            2: y = 32'h0;
            3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            4: y = 32'h0 - 32'($urandom_range(1, 9));
            5: begin x = edge_vals[$urandom_range(0, 4)]; y = edge_vals[$urandom_range(0, 4)]; end
            default: ;
         endcase
         exp_res = model(op, x, y);
         exp_lat = model_lat(op, x, y);
         run_op(op, x, y, lat, stalls, busys, res);
         n_checks++; if (res !== exp_res) $display("FAIL random_result[%0d] op=%b a=%h b=%h: got %h want %h", i, op, x, y, res, exp_res); else n_pass++;
         n_checks++; if (lat != exp_lat) $display("FAIL random_latency[%0d] op=%b: got %0d want %0d", i, op, lat, exp_lat); else n_pass++;
         last_res = exp_res;
      end
   endtask

   task automatic test_back_to_back();
      int          lat, stalls, busys;
      logic [31:0] res;
      run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, lat, stalls, busys, res);
      n_checks++; if (res !== model(OP_DIV, 32'hFFFF_FF9C, 32'd7)) $display("FAIL b2b_div_result: got %h want %h", res, model(OP_DIV, 32'hFFFF_FF9C, 32'd7)); else n_pass++;
      // issue a MUL inside the DIV's done cycle
      start = 1'b1; alufn = OP_MUL; a = 32'd9; b = 32'd11;
      #1;
      n_checks++; if (done !== 1'b1) $display("FAIL b2b_div_done_pulse: got %b want 1", done); else n_pass++;
      n_checks++; if (stall !== 1'b1) $display("FAIL b2b_issue_stall: got %b want 1", stall); else n_pass++;
      @(posedge clk); lat = 1;
      @(negedge clk); start = 1'b0; #1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); lat++;
         @(negedge clk); #1;
      end
      n_checks++; if (lat != 34) $display("FAIL b2b_mul_latency: got %0d want 34", lat); else n_pass++;
      n_checks++; if (result !== 32'd99) $display("FAIL b2b_mul_result: got %h want %h", result, 32'd99); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (done !== 1'b0) $display("FAIL b2b_done_single_cycle: got %b want 0", done); else n_pass++;
      last_res = 32'd99;
   endtask

   task automatic test_start_during_iter();
      int lat;
      @(negedge clk);
      alufn = OP_MUL; a = 32'd7; b = 32'd6; start = 1'b1;
      @(posedge clk); lat = 1;
      // hold a different M op on the inputs through most of the iteration
      @(negedge clk); alufn = OP_DIVU; a = 32'd1000; b = 32'd3;
      repeat (29) begin @(posedge clk); lat++; @(negedge clk); end
      start = 1'b0; #1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); lat++;
         @(negedge clk); #1;
      end
      n_checks++; if (lat != 34) $display("FAIL ignore_latency: got %0d want 34", lat); else n_pass++;
      n_checks++; if (result !== 32'h2A) $display("FAIL ignore_result: got %h want 2a", result); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL ignore_no_relaunch: got busy %b want 0", busy); else n_pass++;
      last_res = 32'h2A;
   endtask

   task automatic test_non_m();
      logic seen_done;
      @(negedge clk);
      alufn = 5'b00000; a = $urandom; b = $urandom; start = 1'b1;
      #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL nonm_stall: got %b want 0", stall); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL nonm_busy: got %b want 0", busy); else n_pass++;
      // M op with a simultaneous flush must not issue either
      alufn = OP_MUL; flush = 1'b1; #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL flush_blocks_issue_stall: got %b want 0", stall); else n_pass++;
      @(negedge clk); start = 1'b0; flush = 1'b0;
      seen_done = 1'b0;
      repeat (5) begin @(negedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1; end
      n_checks++; if (seen_done !== 1'b0) $display("FAIL nonm_no_activity: got %b want 0", seen_done); else n_pass++;
   endtask

   task automatic test_flush();
      logic seen_done;
      @(negedge clk);
      alufn = OP_DIV; a = 32'd1000; b = 32'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0; #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall); else n_pass++;
      n_checks++; if (result !== last_res) $display("FAIL flush_result_held: got %h want %h", result, last_res); else n_pass++;
      seen_done = 1'b0;
      repeat (40) begin @(negedge clk); #1; if (done === 1'b1) seen_done = 1'b1; end
      n_checks++; if (seen_done !== 1'b0) $display("FAIL flush_no_done: got %b want 0", seen_done); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic        seen_done;
      int          lat, stalls, busys;
      logic [31:0] res;
      @(negedge clk);
      alufn = OP_MULHU; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else n_pass++;
      n_checks++; if (result !== 32'h0) $display("FAIL rstmid_result: got %h want 0", result); else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", stall); else n_pass++;
      seen_done = 1'b0;
      repeat (40) begin @(negedge clk); #1; if (done === 1'b1) seen_done = 1'b1; end
      n_checks++; if (seen_done !== 1'b0) $display("FAIL rstmid_no_done: got %b want 0", seen_done); else n_pass++;
      run_op(OP_REMU, 32'd1000, 32'd7, lat, stalls, busys, res);
      n_checks++; if (res !== 32'd6) $display("FAIL rstmid_recover_result: got %h want %h", res, 32'd6); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_start_during_iter();
      test_non_m();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks passed of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
